// File: rtl/fetch_if.sv
// Fetch-stage bus: decode controls, instruction-memory read handshake and IF/ID outputs.
// master = fetch stage, slave = decode/memory side.
interface fetch_if;
    logic        stall;
    logic        doBranch;
    logic [15:0] branchTarget;
    logic [15:0] imemAddr;
    logic        imemRd;
    logic        imemDone;
    logic [15:0] imemData;
    logic [15:0] instrOut;
    logic [15:0] nextPcOut;
    logic        validOut;
    logic        err;

    modport master (
        input  stall, doBranch, branchTarget, imemDone, imemData,
        output imemAddr, imemRd, instrOut, nextPcOut, validOut, err
    );
    modport slave (
        output stall, doBranch, branchTarget, imemDone, imemData,
        input  imemAddr, imemRd, instrOut, nextPcOut, validOut, err
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, handshakes with a multi-cycle imem, drives IF/ID.
// Optional FETCH_ALIGN_CHK_EN: odd PC in RUN halts fetch and sets sticky err.
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    typedef enum logic [1:0] {RUN, WAIT, HOLD, HALTED} state_t;

    state_t      state;
    logic [15:0] pc, tgtPc, holdBuf;
    logic        squash;
    logic        alignBad, reqActive, done, loadEn, isHalt;
    logic [15:0] pcPlus2, loadWord;

`ifdef FETCH_ALIGN_CHK_EN
    assign alignBad = (state == RUN) && pc[0];
`else
    assign alignBad = 1'b0;
`endif

    assign reqActive    = ((state == RUN) && !alignBad) || (state == WAIT);
    assign bus.imemRd   = reqActive;
    assign bus.imemAddr = pc;
    assign done         = reqActive && bus.imemDone;
    assign pcPlus2      = pc + 16'd2;

    always_comb begin
        loadEn   = 1'b0;
        loadWord = bus.imemData;
        if (done && !squash && !bus.stall) begin
            loadEn = 1'b1;
        end else if ((state == HOLD) && !bus.stall) begin
            loadEn   = 1'b1;
            loadWord = holdBuf;
        end
    end
    assign isHalt = (loadWord[15:11] == 5'b00000);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RUN;
            pc            <= RESET_PC;
            tgtPc         <= RESET_PC;
            holdBuf       <= NOP_INSTR;
            squash        <= 1'b0;
            bus.instrOut  <= NOP_INSTR;
            bus.nextPcOut <= 16'h0000;
            bus.validOut  <= 1'b0;
        end else begin
            // IF/ID: flush on redirect, load on acceptance, hold on stall, otherwise drain
            if (bus.doBranch || (!loadEn && !bus.stall)) begin
                bus.instrOut  <= NOP_INSTR;
                bus.nextPcOut <= 16'h0000;
                bus.validOut  <= 1'b0;
            end else if (loadEn) begin
                bus.instrOut  <= loadWord;
                bus.nextPcOut <= pcPlus2;
                bus.validOut  <= 1'b1;
            end

            if (bus.doBranch) begin
                // An in-flight read cannot be aborted: keep the address until it completes
                if (reqActive && !bus.imemDone) begin
                    squash <= 1'b1;
                    tgtPc  <= bus.branchTarget;
                    state  <= WAIT;
                end else begin
                    squash <= 1'b0;
                    pc     <= bus.branchTarget;
                    state  <= RUN;
                end
            end else begin
                case (state)
                    RUN, WAIT: begin
                        if (alignBad) begin
                            state <= HALTED;
                        end else if (done) begin
                            if (squash) begin
                                squash <= 1'b0;
                                pc     <= tgtPc;
                                state  <= RUN;
                            end else if (bus.stall) begin
                                holdBuf <= bus.imemData;
                                state   <= HOLD;
                            end else begin
                                pc    <= pcPlus2;
                                state <= isHalt ? HALTED : RUN;
                            end
                        end else begin
                            state <= WAIT;
                        end
                    end
                    HOLD: begin
                        if (!bus.stall) begin
                            pc    <= pcPlus2;
                            state <= isHalt ? HALTED : RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FETCH_ALIGN_CHK_EN
    logic errQ;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           errQ <= 1'b0;
        else if (alignBad) errQ <= 1'b1;
    end
    assign bus.err = errQ;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-configurable instruction memory model.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst;
    logic [3:0]  memLat;
    logic [3:0]  waitCnt;
    logic [15:0] mem [256];
    int nTests = 0;
    int nFail  = 0;

    fetch_if bus ();

    fetch_stage #(.RESET_PC(16'h0000), .NOP_INSTR(16'h0800)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    // Memory completes after memLat cycles of continuous request (1 = same cycle)
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              waitCnt <= 4'd0;
        else if (bus.imemRd && !bus.imemDone) waitCnt <= waitCnt + 4'd1;
        else                                  waitCnt <= 4'd0;
    end
    assign bus.imemDone = bus.imemRd && (waitCnt == memLat - 4'd1);
    assign bus.imemData = mem[bus.imemAddr[8:1]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 | 16'(i);
        mem[0] = 16'hC001;
        mem[1] = 16'hC002;
        mem[2] = 16'hC003;
        mem[3] = 16'h0000;   // HALT at 0x0006

        rst = 1'b1; memLat = 4'd1;
        bus.stall = 1'b0; bus.doBranch = 1'b0; bus.branchTarget = 16'h0000;
        #3;
        chk("rst_instr", bus.instrOut, 16'h0800);
        chk("rst_npc",   bus.nextPcOut, 16'h0000);
        chk("rst_valid", bus.validOut, 1'b0);
        chk("rst_err",   bus.err, 1'b0);
        chk("rst_addr",  bus.imemAddr, 16'h0000);
        tick(); rst = 1'b0;

        // straight-line, single-cycle memory, ending in HALT
        chk("s_rd0",   bus.imemRd, 1'b1);
        chk("s_addr0", bus.imemAddr, 16'h0000);
        tick();
        chk("s_addr2", bus.imemAddr, 16'h0002);
        chk("s_i1",    bus.instrOut, 16'hC001);
        chk("s_np1",   bus.nextPcOut, 16'h0002);
        chk("s_v1",    bus.validOut, 1'b1);
        tick();
        chk("s_addr4", bus.imemAddr, 16'h0004);
        chk("s_i2",    bus.instrOut, 16'hC002);
        chk("s_np2",   bus.nextPcOut, 16'h0004);
        tick();
        chk("s_addr6", bus.imemAddr, 16'h0006);
        chk("s_i3",    bus.instrOut, 16'hC003);
        chk("s_np3",   bus.nextPcOut, 16'h0006);
        tick();
        chk("h_instr", bus.instrOut, 16'h0000);
        chk("h_np",    bus.nextPcOut, 16'h0008);
        chk("h_valid", bus.validOut, 1'b1);
        chk("h_rd",    bus.imemRd, 1'b0);
        tick();
        chk("h_drainv", bus.validOut, 1'b0);
        chk("h_draini", bus.instrOut, 16'h0800);
        repeat (3) tick();
        chk("h_rdlate", bus.imemRd, 1'b0);
        chk("h_vlate",  bus.validOut, 1'b0);
        bus.doBranch = 1'b1; bus.branchTarget = 16'h0010;
        tick(); bus.doBranch = 1'b0;
        chk("hb_valid", bus.validOut, 1'b0);
        chk("hb_addr",  bus.imemAddr, 16'h0010);
        chk("hb_rd",    bus.imemRd, 1'b1);
        tick();
        chk("hb_instr", bus.instrOut, 16'hA008);
        chk("hb_np",    bus.nextPcOut, 16'h0012);
        chk("hb_v",     bus.validOut, 1'b1);

        // 3-cycle memory with stall arriving alongside completion
        rst = 1'b1; memLat = 4'd3;
        tick(); rst = 1'b0;
        chk("m_addr0", bus.imemAddr, 16'h0000);
        tick();
        chk("m_wrd",   bus.imemRd, 1'b1);
        chk("m_wv",    bus.validOut, 1'b0);
        tick(); tick();
        chk("m_i1",    bus.instrOut, 16'hC001);
        chk("m_np1",   bus.nextPcOut, 16'h0002);
        chk("m_addr2", bus.imemAddr, 16'h0002);
        tick(); tick();
        bus.stall = 1'b1;
        tick();
        chk("st_rd",   bus.imemRd, 1'b0);
        chk("st_v",    bus.validOut, 1'b0);
        chk("st_i",    bus.instrOut, 16'h0800);
        tick();
        chk("st_rd2",  bus.imemRd, 1'b0);
        chk("st_v2",   bus.validOut, 1'b0);
        bus.stall = 1'b0;
        tick();
        chk("st_i2",   bus.instrOut, 16'hC002);
        chk("st_np2",  bus.nextPcOut, 16'h0004);
        chk("st_v3",   bus.validOut, 1'b1);
        chk("st_addr", bus.imemAddr, 16'h0004);

        // branch while a read is outstanding
        tick();
        bus.doBranch = 1'b1; bus.branchTarget = 16'h0040;
        tick(); bus.doBranch = 1'b0;
        chk("b_v",     bus.validOut, 1'b0);
        chk("b_addrh", bus.imemAddr, 16'h0004);
        chk("b_rd",    bus.imemRd, 1'b1);
        tick();
        chk("b_addrn", bus.imemAddr, 16'h0040);
        chk("b_v2",    bus.validOut, 1'b0);
        tick(); tick(); tick();
        chk("b_instr", bus.instrOut, 16'hA020);
        chk("b_np",    bus.nextPcOut, 16'h0042);
        chk("b_v3",    bus.validOut, 1'b1);
        bus.stall = 1'b1;
        tick();
        chk("r_vpre",  bus.validOut, 1'b1);
        chk("r_apre",  bus.imemAddr, 16'h0042);

        // asynchronous reset mid-WAIT
        #2 rst = 1'b1;
        #1;
        chk("r_v",     bus.validOut, 1'b0);
        chk("r_i",     bus.instrOut, 16'h0800);
        chk("r_np",    bus.nextPcOut, 16'h0000);
        chk("r_addr",  bus.imemAddr, 16'h0000);
        bus.stall = 1'b0; memLat = 4'd1;
        tick(); rst = 1'b0;
        chk("r_rd",    bus.imemRd, 1'b1);
        chk("r_a0",    bus.imemAddr, 16'h0000);
        tick();
        chk("r_i1",    bus.instrOut, 16'hC001);

        // branch to an odd address
        bus.doBranch = 1'b1; bus.branchTarget = 16'h0011;
        tick(); bus.doBranch = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        chk("a_rd",    bus.imemRd, 1'b0);
        tick();
        chk("a_err",   bus.err, 1'b1);
        chk("a_rd2",   bus.imemRd, 1'b0);
        tick();
        chk("a_errs",  bus.err, 1'b1);
`else
        chk("a_addr",  bus.imemAddr, 16'h0011);
        chk("a_rd",    bus.imemRd, 1'b1);
        chk("a_err",   bus.err, 1'b0);
        tick();
        chk("a_i",     bus.instrOut, 16'hA008);
        chk("a_np",    bus.nextPcOut, 16'h0013);
`endif
        bus.doBranch = 1'b1; bus.branchTarget = 16'h0020;
        tick(); bus.doBranch = 1'b0;
        chk("a2_addr", bus.imemAddr, 16'h0020);
        chk("a2_rd",   bus.imemRd, 1'b1);
`ifdef FETCH_ALIGN_CHK_EN
        chk("a2_err",  bus.err, 1'b1);
`else
        chk("a2_err",  bus.err, 1'b0);
`endif
        tick();
        chk("a2_i",    bus.instrOut, 16'hA010);
        chk("a2_v",    bus.validOut, 1'b1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
